// File: rtl/truth_table_sweeper.sv
// Steps a combinational gate through every input vector, holding each for HOLD
// cycles, and scores its output against a golden truth table captured at start.
//
// state | meaning
// IDLE  | after reset; waiting for start
// DRIVE | sweep in progress, vec driven to the gate
// DONE  | sweep complete, results held until the next start
module truth_table_sweeper #(
  parameter int WIDTH = 3,
  parameter int HOLD  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2**WIDTH-1:0]   expected,
  input  logic                  dut_y,
  output logic [WIDTH-1:0]      vec,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [WIDTH:0]        err_count,
  output logic [WIDTH-1:0]      first_fail,
  output logic                  fail_seen
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);
  localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
  localparam logic [WIDTH-1:0] VEC_ONE   = WIDTH'(1);
  localparam logic [WIDTH:0]   ERR_ONE   = (WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      vec_q, vec_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [WIDTH:0]        err_q, err_d;
  logic [WIDTH-1:0]      first_q, first_d;
  logic                  seen_q, seen_d;
  logic [2**WIDTH-1:0]   exp_q, exp_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      first_q <= first_d;
      seen_q  <= seen_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    err_d   = err_q;
    first_d = first_q;
    seen_d  = seen_q;
    exp_d   = exp_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          first_d = '0;
          seen_d  = 1'b0;
          exp_d   = expected;
        end
      end
      S_DRIVE: begin
        // Compare only on the last cycle of the hold window so the gate output has settled.
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (dut_y != exp_q[vec_q]) begin
            err_d = err_q + ERR_ONE;
            if (!seen_q) begin
              first_d = vec_q;
              seen_d  = 1'b1;
            end
          end
          if (&vec_q) state_d = S_DONE;
          else        vec_d   = vec_q + VEC_ONE;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign vec        = vec_q;
  assign busy       = (state_q == S_DRIVE);
  assign done       = (state_q == S_DONE);
  assign pass       = done && (err_q == '0);
  assign err_count  = err_q;
  assign first_fail = first_q;
  assign fail_seen  = seen_q;

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter WIDTH, default 3, number of DUT inputs; legal 1..4.
REQ-002 Parameter HOLD, default 2, clock cycles each input vector is held; legal 1..15.
REQ-003 Design decision: one clock; reset asynchronous, active-high.
REQ-004 clk  input  1  the only clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 start  input  1  level sampled on clk; begins a sweep from IDLE or DONE.
REQ-007 expected  input  2**WIDTH  golden truth table; bit i = required Y for input vector i.
REQ-008 dut_y  input  1  output of the combinational gate under test.
REQ-009 vec  output  WIDTH  input vector driven to DUT; MSB maps to DUT input A.
REQ-010 busy  output  1  high while sweeping.
REQ-011 done  output  1  high from sweep completion until next accepted start.
REQ-012 pass  output  1  valid when done=1; 1 = zero mismatches.
REQ-013 err_count  output  WIDTH+1  mismatch count of the current or last sweep.
REQ-014 first_fail  output  WIDTH  lowest-index vector that mismatched; valid when fail_seen=1.
REQ-015 fail_seen  output  1  at least one mismatch in the current or last sweep.

Function
REQ-016 Sweeper SHALL implement FSM states IDLE, DRIVE, DONE.
REQ-017 IDLE --start=1--> DRIVE: vec<=0, hold counter<=0, err_count<=0, fail_seen<=0, first_fail<=0, expected captured into internal register.
REQ-018 Start SHALL be ignored while in DRIVE; expected changes during DRIVE SHALL have no effect.
REQ-019 In DRIVE, hold counter SHALL increment each cycle from 0 to HOLD-1, then return to 0.
REQ-020 On the edge where hold counter = HOLD-1, dut_y SHALL be compared against captured expected[vec].
REQ-021 On mismatch, err_count SHALL increment by 1; if fail_seen=0, first_fail<=vec and fail_seen<=1 on the same edge.
REQ-022 On the compare edge with vec < 2**WIDTH-1: vec<=vec+1, state stays DRIVE.
REQ-023 On the compare edge with vec = 2**WIDTH-1: state<=DONE; vec SHALL hold its final value (no wrap to 0).
REQ-024 Sweep length SHALL be exactly HOLD*2**WIDTH cycles; done rises on the edge HOLD*2**WIDTH cycles after the start-accept edge.
REQ-025 busy = (state==DRIVE); done = (state==DONE); pass = done & (err_count==0); all decoded from registers (no dut_y combinational path).
REQ-026 DONE --start=1--> DRIVE with the same initialisation as REQ-017; otherwise DONE holds all results.
REQ-027 err_count SHALL never overflow: maximum 2**WIDTH fits in WIDTH+1 bits.
REQ-028 HOLD=1 SHALL compare on every DRIVE cycle.

Reset
REQ-029 reset=1 SHALL immediately force state=IDLE, vec=0, hold counter=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_seen=0, regardless of clk.
REQ-030 Reset asserted mid-sweep SHALL abort it; no result retained; first edge after release with start=1 begins a fresh sweep.

Verification
REQ-031 WIDTH=3, HOLD=2, DUT = majority(A,B,C), expected=8'b1110_1000, start pulse at edge t0 -> vec steps 0..7, each held 2 cycles; done=1 at t0+16, pass=1, err_count=0, fail_seen=0.
REQ-032 Same DUT, expected=8'b1110_1001 -> done at t0+16, pass=0, err_count=1, first_fail=0, fail_seen=1.
REQ-033 WIDTH=4, HOLD=1, DUT output stuck 0, expected=16'hFFFF -> done at t0+16, err_count=16, first_fail=0.
REQ-034 Start held high through the whole sweep and expected toggled at t0+5 -> results identical to REQ-031; sweep restarts only from DONE (done at t0+16, busy again at t0+17).
REQ-035 reset asserted asynchronously between edges at t0+7 -> all outputs 0 without waiting for clk; start after release gives a full 16-cycle sweep with correct results.
REQ-036 Start at DONE after a failing sweep with a passing expected -> err_count, fail_seen cleared on accept edge; pass=1 at completion.
